dmem_arbiter: RTL and testbench
===============================

DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 Parameter: DMEM_BYTES, default 32, data memory size in bytes.
REQ-002 Parameter: RESET_LAST_GNT, default 1, last-grant value after reset (1 means port 0 wins the first tie).
REQ-003 clk_i  input  1  single clock; all state updates on posedge.
REQ-004 rst_i  input  1  reset, synchronous, active-high.
REQ-005 m0_req_i / m1_req_i  input  1  request from port 0 (CPU MEM stage) / port 1 (loader/debug).
REQ-006 mX_we_i  input  1  1 = write, 0 = read.
REQ-007 mX_addr_i  input  32  byte address.
REQ-008 mX_wdata_i  input  32  write data.
REQ-009 mX_gnt_o  output  1  request accepted this cycle.
REQ-010 mX_rvalid_o  output  1  one-cycle response strobe, for both reads and writes.
REQ-011 mX_rdata_o  output  32  read data, valid only with rvalid.
REQ-012 mX_err_o  output  1  error flag, valid only with rvalid.
REQ-013 mem_addr_o  output  32  address to the data memory.
REQ-014 mem_read_o / mem_write_o  output  1  memory read / write enables.
REQ-015 mem_wdata_o  output  32  memory write data.
REQ-016 mem_rdata_i  input  32  memory read data; combinational, 0 when mem_read_o is low.

Function
REQ-017 FSM states: IDLE, ACCESS, RESP.
REQ-018 Grants issue only in IDLE or RESP; gnt is combinational from req and state; at most one gnt per cycle.
REQ-019 Arbitration: single requester wins; if both request, the port not granted last wins; last_gnt updates on every grant.
REQ-020 On grant: the winner's we, addr, wdata and id are registered, and the next state is ACCESS.
REQ-021 ACCESS lasts exactly one cycle; mem_addr_o and mem_wdata_o come from the registered values.
REQ-022 In ACCESS, mem_read_o = !we and mem_write_o = we; the memory performs the write at the ACCESS-ending edge.
REQ-023 In ACCESS, mem_rdata_i is captured into the response register on reads; for writes the response register captures 0.
REQ-024 RESP lasts one cycle: rvalid_o for the owning port only, with rdata and err from the registers.
REQ-025 From RESP: next state is ACCESS if a grant issues in that cycle, else IDLE.
REQ-026 Latency: gnt at cycle N -> rvalid at N+2; peak throughput is one access per 2 cycles.
REQ-027 Illegal access: addr[1:0] != 0 or addr > DMEM_BYTES-4.
REQ-028 For an illegal access, the ACCESS cycle keeps mem_read_o and mem_write_o at 0, and the response carries err_o=1, rdata_o=0.
REQ-029 Outside ACCESS, all mem_* outputs are 0.
REQ-030 A requester holds req and its payload until it sees gnt; a request dropped before gnt is ignored.
REQ-031 Simultaneous gnt to one port and rvalid to the other port (RESP state) is legal.

Reset
REQ-032 While rst_i is high: state <= IDLE and last_gnt <= RESET_LAST_GNT.
REQ-033 While rst_i is high, all gnt, rvalid, err, mem_read and mem_write outputs are 0, and all data outputs are 0.
REQ-034 Reset asserted during ACCESS forces mem_write_o=0 combinationally: the pending write is dropped and no response is issued.
REQ-035 No request is granted in a cycle with rst_i high.

Structure
REQ-036 A shared package holds the FSM state encoding, DMEM_BYTES, and the illegal-address check function.
REQ-037 A single sub-module, rr_arb2 (2-way round-robin with last_gnt register), produces the grant; the FSM and datapath live in dmem_arbiter.

Verification
REQ-038 Reset, then m0 writes 0xDEADBEEF at addr 8 -> gnt at N; mem_write_o=1 with addr 8 at N+1; m0_rvalid at N+2 with err=0.
REQ-039 m1 reads addr 8 after the write -> m1_rvalid at N+2 with rdata=0xDEADBEEF.
REQ-040 m0 and m1 both request continuously from reset -> grants alternate m0, m1, m0, ...; one grant every 2 cycles.
REQ-041 m0 reads addr 6, then addr 32 -> each access: no mem_read_o pulse; rvalid with err=1, rdata=0.
REQ-042 rst_i asserted in the ACCESS cycle of a write of 0x12345678 to addr 4 -> mem_write_o=0 and no rvalid; a later read of addr 4 returns the prior value.
REQ-043 m1 gnt issued in RESP of an m0 read -> m0_rvalid and m1_gnt in the same cycle; m1 ACCESS occurs the next cycle.

Source files
------------

// File: rtl/dmem_arbiter_pkg.sv
// Shared types, sizes and the address legality check for the data-memory arbiter.
package dmem_arbiter_pkg;

    localparam int unsigned XLEN       = 32;
    localparam int unsigned DMEM_BYTES = 32;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2
    } state_t;

    // Payload captured from the winning port at grant time.
    typedef struct packed {
        logic            we;
        logic [XLEN-1:0] addr;
        logic [XLEN-1:0] wdata;
    } dmem_req_t;

    // Misaligned or past the last full word of the memory.
    function automatic logic addr_illegal(input logic [XLEN-1:0] addr,
                                          input int unsigned     mem_bytes);
        return (addr[1:0] != 2'b00) || (addr > XLEN'(mem_bytes - 4));
    endfunction

endpackage

// File: rtl/dmem_arbiter_rr_arb2.sv
// Two-way round-robin arbiter; remembers the last granted port.
module rr_arb2 #(
    parameter bit RESET_LAST_GNT = 1'b1
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       en_i,
    input  logic [1:0] req_i,
    output logic [1:0] gnt_o
);

    logic last_gnt_q;

    // Single requester wins; on a tie the port not granted last wins.
    always_comb begin
        gnt_o = 2'b00;
        if (en_i && !rst_i) begin
            unique case (req_i)
                2'b01:   gnt_o = 2'b01;
                2'b10:   gnt_o = 2'b10;
                2'b11:   gnt_o = last_gnt_q ? 2'b01 : 2'b10;
                default: gnt_o = 2'b00;
            endcase
        end
    end

    // Track which port received the most recent grant.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            last_gnt_q <= RESET_LAST_GNT;
        end else if (gnt_o[0]) begin
            last_gnt_q <= 1'b0;
        end else if (gnt_o[1]) begin
            last_gnt_q <= 1'b1;
        end
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Two-port data-memory arbiter: grant, one ACCESS cycle, one RESP cycle.
module dmem_arbiter
    import dmem_arbiter_pkg::*;
#(
    parameter int unsigned DMEM_BYTES     = dmem_arbiter_pkg::DMEM_BYTES,
    parameter bit          RESET_LAST_GNT = 1'b1
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            m0_req_i,
    input  logic            m0_we_i,
    input  logic [XLEN-1:0] m0_addr_i,
    input  logic [XLEN-1:0] m0_wdata_i,
    output logic            m0_gnt_o,
    output logic            m0_rvalid_o,
    output logic [XLEN-1:0] m0_rdata_o,
    output logic            m0_err_o,
    input  logic            m1_req_i,
    input  logic            m1_we_i,
    input  logic [XLEN-1:0] m1_addr_i,
    input  logic [XLEN-1:0] m1_wdata_i,
    output logic            m1_gnt_o,
    output logic            m1_rvalid_o,
    output logic [XLEN-1:0] m1_rdata_o,
    output logic            m1_err_o,
    output logic [XLEN-1:0] mem_addr_o,
    output logic            mem_read_o,
    output logic            mem_write_o,
    output logic [XLEN-1:0] mem_wdata_o,
    input  logic [XLEN-1:0] mem_rdata_i
);

    state_t          state_q;
    dmem_req_t       req_q;
    logic            id_q;
    logic            illegal_q;
    logic [XLEN-1:0] rdata_q;
    logic            err_q;

    logic [1:0]      gnt;
    logic            grant_en;
    logic            in_access;
    logic            in_resp;
    dmem_req_t       win_req;

    assign grant_en = (state_q == ST_IDLE) || (state_q == ST_RESP);

    rr_arb2 #(
        .RESET_LAST_GNT (RESET_LAST_GNT)
    ) u_arb (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .en_i  (grant_en),
        .req_i ({m1_req_i, m0_req_i}),
        .gnt_o (gnt)
    );

    assign m0_gnt_o = gnt[0];
    assign m1_gnt_o = gnt[1];

    // Payload of whichever port wins this cycle.
    always_comb begin
        win_req = '{we: m0_we_i, addr: m0_addr_i, wdata: m0_wdata_i};
        if (gnt[1]) begin
            win_req = '{we: m1_we_i, addr: m1_addr_i, wdata: m1_wdata_i};
        end
    end

    // FSM with request capture and response register.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= ST_IDLE;
            req_q     <= '0;
            id_q      <= 1'b0;
            illegal_q <= 1'b0;
            rdata_q   <= '0;
            err_q     <= 1'b0;
        end else begin
            unique case (state_q)
                ST_IDLE, ST_RESP: begin
                    if (|gnt) begin
                        state_q   <= ST_ACCESS;
                        req_q     <= win_req;
                        id_q      <= gnt[1];
                        illegal_q <= addr_illegal(win_req.addr, DMEM_BYTES);
                    end else begin
                        state_q <= ST_IDLE;
                    end
                end
                ST_ACCESS: begin
                    state_q <= ST_RESP;
                    rdata_q <= (!req_q.we && !illegal_q) ? mem_rdata_i : '0;
                    err_q   <= illegal_q;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    // Reset gates outputs immediately so an in-flight write never reaches memory.
    assign in_access = (state_q == ST_ACCESS) && !rst_i;
    assign in_resp   = (state_q == ST_RESP) && !rst_i;

    assign mem_addr_o  = in_access ? req_q.addr  : '0;
    assign mem_wdata_o = in_access ? req_q.wdata : '0;
    assign mem_read_o  = in_access && !req_q.we && !illegal_q;
    assign mem_write_o = in_access &&  req_q.we && !illegal_q;

    assign m0_rvalid_o = in_resp && !id_q;
    assign m1_rvalid_o = in_resp &&  id_q;
    assign m0_rdata_o  = m0_rvalid_o ? rdata_q : '0;
    assign m1_rdata_o  = m1_rvalid_o ? rdata_q : '0;
    assign m0_err_o    = m0_rvalid_o && err_q;
    assign m1_err_o    = m1_rvalid_o && err_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a small word memory model.
module tb_dmem_arbiter;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        m0_req_i, m0_we_i, m1_req_i, m1_we_i;
    logic [31:0] m0_addr_i, m0_wdata_i, m1_addr_i, m1_wdata_i;
    logic        m0_gnt_o, m0_rvalid_o, m0_err_o;
    logic        m1_gnt_o, m1_rvalid_o, m1_err_o;
    logic [31:0] m0_rdata_o, m1_rdata_o;
    logic [31:0] mem_addr_o, mem_wdata_o, mem_rdata_i;
    logic        mem_read_o, mem_write_o;

    logic [31:0] mem [8];
    logic        mem_init;

    int errors = 0;
    int checks = 0;

    localparam logic [31:0] DBEEF = 32'hDEADBEEF;
    localparam logic [31:0] P0    = 32'h01020304;
    localparam logic [31:0] P4    = 32'h11112222;
    localparam logic [31:0] P28   = 32'hA5A55A5A;

    always #5 clk_i = ~clk_i;

    dmem_arbiter #(.DMEM_BYTES(32), .RESET_LAST_GNT(1'b1)) dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .m0_req_i    (m0_req_i),
        .m0_we_i     (m0_we_i),
        .m0_addr_i   (m0_addr_i),
        .m0_wdata_i  (m0_wdata_i),
        .m0_gnt_o    (m0_gnt_o),
        .m0_rvalid_o (m0_rvalid_o),
        .m0_rdata_o  (m0_rdata_o),
        .m0_err_o    (m0_err_o),
        .m1_req_i    (m1_req_i),
        .m1_we_i     (m1_we_i),
        .m1_addr_i   (m1_addr_i),
        .m1_wdata_i  (m1_wdata_i),
        .m1_gnt_o    (m1_gnt_o),
        .m1_rvalid_o (m1_rvalid_o),
        .m1_rdata_o  (m1_rdata_o),
        .m1_err_o    (m1_err_o),
        .mem_addr_o  (mem_addr_o),
        .mem_read_o  (mem_read_o),
        .mem_write_o (mem_write_o),
        .mem_wdata_o (mem_wdata_o),
        .mem_rdata_i (mem_rdata_i)
    );

    // Combinational-read, clocked-write memory model.
    assign mem_rdata_i = mem_read_o ? mem[mem_addr_o[4:2]] : 32'h0;

    always @(posedge clk_i) begin
        if (mem_init) begin
            for (int i = 0; i < 8; i++) mem[i] <= 32'h0;
            mem[0] <= P0;
            mem[1] <= P4;
            mem[7] <= P28;
        end else if (mem_write_o) begin
            mem[mem_addr_o[4:2]] <= mem_wdata_o;
        end
    end

    typedef struct {
        logic        rst;
        logic        r0, w0;
        logic [31:0] a0, d0;
        logic        r1, w1;
        logic [31:0] a1, d1;
        logic [1:0]  gnt, rv, err;
        logic [31:0] rd0, rd1;
        logic        mrd, mwr;
        logic [31:0] maddr, mwd;
    } vec_t;

    function automatic vec_t mk(input int unsigned rst, r0, w0, a0, d0, r1, w1, a1, d1,
                                input int unsigned g, rv, er, rd0, rd1, mrd, mwr, ma, mwd);
        vec_t v;
        v.rst = 1'(rst);  v.r0 = 1'(r0);  v.w0 = 1'(w0);  v.a0 = 32'(a0);  v.d0 = 32'(d0);
        v.r1 = 1'(r1);    v.w1 = 1'(w1);  v.a1 = 32'(a1); v.d1 = 32'(d1);
        v.gnt = 2'(g);    v.rv = 2'(rv);  v.err = 2'(er);
        v.rd0 = 32'(rd0); v.rd1 = 32'(rd1);
        v.mrd = 1'(mrd);  v.mwr = 1'(mwr); v.maddr = 32'(ma); v.mwd = 32'(mwd);
        return v;
    endfunction

    task automatic chk(input string nm, input int idx, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s[%0d]: got %h expected %h", nm, idx, act, exp);
        end
    endtask

    task automatic drive(input logic rst, input logic r0, input logic w0, input logic [31:0] a0,
                         input logic [31:0] d0, input logic r1, input logic w1,
                         input logic [31:0] a1, input logic [31:0] d1);
        rst_i = rst;
        m0_req_i = r0; m0_we_i = w0; m0_addr_i = a0; m0_wdata_i = d0;
        m1_req_i = r1; m1_we_i = w1; m1_addr_i = a1; m1_wdata_i = d1;
    endtask

    vec_t vq[$];

    initial begin
        // rst r0 w0 a0 d0  r1 w1 a1 d1  gnt rv err  rd0 rd1  mrd mwr maddr mwd
        vq.push_back(mk(1, 1,1,8,DBEEF, 1,0,8,0, 0,0,0, 0,0,       0,0,0,0));
        vq.push_back(mk(1, 1,1,8,DBEEF, 1,0,8,0, 0,0,0, 0,0,       0,0,0,0));
        vq.push_back(mk(0, 1,1,8,DBEEF, 0,0,0,0, 1,0,0, 0,0,       0,0,0,0));
        vq.push_back(mk(0, 0,0,0,0,     0,0,0,0, 0,0,0, 0,0,       0,1,8,DBEEF));
        vq.push_back(mk(0, 0,0,0,0,     0,0,0,0, 0,1,0, 0,0,       0,0,0,0));
        vq.push_back(mk(0, 0,0,0,0,     1,0,8,0, 2,0,0, 0,0,       0,0,0,0));
        vq.push_back(mk(0, 0,0,0,0,     0,0,0,0, 0,0,0, 0,0,       1,0,8,0));
        vq.push_back(mk(0, 0,0,0,0,     0,0,0,0, 0,2,0, 0,DBEEF,   0,0,0,0));
        vq.push_back(mk(0, 1,0,6,0,     0,0,0,0, 1,0,0, 0,0,       0,0,0,0));
        vq.push_back(mk(0, 0,0,0,0,     0,0,0,0, 0,0,0, 0,0,       0,0,6,0));
        vq.push_back(mk(0, 1,0,32,0,    0,0,0,0, 1,1,1, 0,0,       0,0,0,0));
        vq.push_back(mk(0, 0,0,0,0,     0,0,0,0, 0,0,0, 0,0,       0,0,32,0));
        vq.push_back(mk(0, 0,0,0,0,     0,0,0,0, 0,1,1, 0,0,       0,0,0,0));
        vq.push_back(mk(0, 1,0,28,0,    0,0,0,0, 1,0,0, 0,0,       0,0,0,0));
        vq.push_back(mk(0, 0,0,0,0,     0,0,0,0, 0,0,0, 0,0,       1,0,28,0));
        vq.push_back(mk(0, 0,0,0,0,     1,0,4,0, 2,1,0, P28,0,     0,0,0,0));
        vq.push_back(mk(0, 0,0,0,0,     0,0,0,0, 0,0,0, 0,0,       1,0,4,0));
        vq.push_back(mk(0, 0,0,0,0,     0,0,0,0, 0,2,0, 0,P4,      0,0,0,0));
        vq.push_back(mk(0, 1,0,0,0,     1,0,4,0, 1,0,0, 0,0,       0,0,0,0));
        vq.push_back(mk(0, 0,0,0,0,     1,0,4,0, 0,0,0, 0,0,       1,0,0,0));
        vq.push_back(mk(0, 1,0,0,0,     1,0,4,0, 2,1,0, P0,0,      0,0,0,0));
        vq.push_back(mk(0, 1,0,0,0,     0,0,0,0, 0,0,0, 0,0,       1,0,4,0));
        vq.push_back(mk(0, 1,0,0,0,     1,0,4,0, 1,2,0, 0,P4,      0,0,0,0));
        vq.push_back(mk(0, 0,0,0,0,     1,0,4,0, 0,0,0, 0,0,       1,0,0,0));
        vq.push_back(mk(0, 0,0,0,0,     1,0,4,0, 2,1,0, P0,0,      0,0,0,0));
        vq.push_back(mk(0, 0,0,0,0,     0,0,0,0, 0,0,0, 0,0,       1,0,4,0));
        vq.push_back(mk(0, 0,0,0,0,     0,0,0,0, 0,2,0, 0,P4,      0,0,0,0));
        vq.push_back(mk(0, 0,0,0,0,     0,0,0,0, 0,0,0, 0,0,       0,0,0,0));

        // Preload memory while the design is held in reset.
        mem_init = 1'b1;
        drive(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
        repeat (2) @(negedge clk_i);
        mem_init = 1'b0;

        // Table: drive after the falling edge, compare just before the rising edge.
        foreach (vq[i]) begin
            if (i != 0) @(negedge clk_i);
            drive(vq[i].rst, vq[i].r0, vq[i].w0, vq[i].a0, vq[i].d0,
                  vq[i].r1, vq[i].w1, vq[i].a1, vq[i].d1);
            #3;
            chk("gnt",       i, 32'({m1_gnt_o, m0_gnt_o}),       32'(vq[i].gnt));
            chk("rvalid",    i, 32'({m1_rvalid_o, m0_rvalid_o}), 32'(vq[i].rv));
            chk("err",       i, 32'({m1_err_o, m0_err_o}),       32'(vq[i].err));
            chk("m0_rdata",  i, m0_rdata_o,                      vq[i].rd0);
            chk("m1_rdata",  i, m1_rdata_o,                      vq[i].rd1);
            chk("mem_read",  i, 32'(mem_read_o),                 32'(vq[i].mrd));
            chk("mem_write", i, 32'(mem_write_o),                32'(vq[i].mwr));
            chk("mem_addr",  i, mem_addr_o,                      vq[i].maddr);
            chk("mem_wdata", i, mem_wdata_o,                     vq[i].mwd);
        end

        // Reset during the ACCESS of a write drops it and suppresses the response.
        @(negedge clk_i);
        drive(1'b0, 1'b1, 1'b1, 32'd4, 32'h12345678, 1'b0, 1'b0, 32'h0, 32'h0);
        #3 chk("abort_gnt", 0, 32'(m0_gnt_o), 32'd1);
        @(negedge clk_i);
        drive(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
        #3 chk("abort_mem_write", 0, 32'(mem_write_o), 32'd0);
        chk("abort_mem_addr", 0, mem_addr_o, 32'h0);
        @(negedge clk_i);
        drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
        #3 chk("abort_rvalid", 0, 32'(m0_rvalid_o), 32'd0);
        @(negedge clk_i);
        drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 32'd4, 32'h0);
        #3 chk("abort_rd_gnt", 0, 32'(m1_gnt_o), 32'd1);
        @(negedge clk_i);
        drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
        #3 chk("abort_rd_mem_read", 0, 32'(mem_read_o), 32'd1);
        @(negedge clk_i);
        #3 chk("abort_rd_rvalid", 0, 32'(m1_rvalid_o), 32'd1);
        chk("abort_rd_rdata", 0, m1_rdata_o, P4);

        // Both ports request continuously from reset: grants alternate every 2 cycles.
        @(negedge clk_i);
        drive(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
        for (int k = 0; k < 12; k++) begin
            logic [1:0] eg;
            logic [1:0] erv;
            @(negedge clk_i);
            drive(1'b0, 1'b1, 1'b0, 32'd0, 32'h0, 1'b1, 1'b0, 32'd4, 32'h0);
            eg  = 2'b00;
            erv = 2'b00;
            if (k % 2 == 0) eg = ((k / 2) % 2 == 0) ? 2'b01 : 2'b10;
            if (k % 2 == 0 && k >= 2) erv = (((k / 2) - 1) % 2 == 0) ? 2'b01 : 2'b10;
            #3;
            chk("alt_gnt",    k, 32'({m1_gnt_o, m0_gnt_o}),       32'(eg));
            chk("alt_rvalid", k, 32'({m1_rvalid_o, m0_rvalid_o}), 32'(erv));
        end

        @(negedge clk_i);
        drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
